// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   fetch_state_t  fetch sequencer states (idle, request, wait, drain)
//   FETCH_DEPTH    entries in the fetch buffer
//   CNT_W          width of the buffer occupancy count
//   *_HI/*_LO      instruction field bit positions
//   fetch_entry_t  one buffered fetch: {instr, pc, err}
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam int FETCH_DEPTH = 2;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO holding fetched instruction entries
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   push, wdata    write one entry (accepted when not full, or when popping same cycle)
//   pop            remove the head entry (ignored when empty)
//   flush          empty the FIFO; beats a simultaneous push or pop
//   rdata          head entry
//   count, empty   occupancy
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word in the cycle its head leaves.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with one outstanding memory request and a 2-entry buffer
//
// Ports:
//   CLK, MasterReset                 clock, synchronous active-high reset
//   PC, fetch_en, flush              fetch address, fetch enable, redirect
//   pc_advance                       pulse: current PC accepted by memory
//   imem_req/imem_addr/imem_gnt      request channel to instruction memory
//   imem_rvalid/imem_rdata/imem_err  response channel from instruction memory
//   instr/instr_pc/instr_err         buffer head
//   instr_valid/instr_ready          handshake to decode
//   opcode..imm16                    field split of instr
//   misaligned_fault                 sticky misaligned-PC flag
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        MasterReset,
  input  logic [31:0] PC,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        misaligned_fault
);

  fetch_state_t     state, state_next;
  logic [31:0]      addr_q;
  logic             load_addr;
  logic             fault_q;
  logic             push, pop, fifo_empty;
  logic             pc_aligned, start_ok;
  logic [CNT_W-1:0] count, count_next;
  fetch_entry_t     wentry, head;

  assign pc_aligned = (PC[1:0] == 2'b00);
  // Everything needed to start a fetch except buffer room, which depends on the state.
  assign start_ok   = fetch_en && !flush && pc_aligned && !fault_q;

  // Only a response to a live request in WAIT is kept; DRAIN and idle responses fall on the floor.
  assign push       = (state == S_WAIT) && imem_rvalid && !flush;
  assign pop        = instr_valid && instr_ready;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign imem_req   = (state == S_REQ);
  assign imem_addr  = addr_q;
  assign pc_advance = (state == S_REQ) && imem_gnt && !flush && !MasterReset;

  assign wentry = '{instr: imem_rdata, pc: addr_q, err: imem_err};

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (MasterReset),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (count),
    .empty (fifo_empty)
  );

  assign instr_valid      = !fifo_empty;
  assign instr            = head.instr;
  assign instr_pc         = head.pc;
  assign instr_err        = head.err;
  assign misaligned_fault = fault_q;

  assign opcode = instr[OPCODE_HI:OPCODE_LO];
  assign rs     = instr[RS_HI:RS_LO];
  assign rt     = instr[RT_HI:RT_LO];
  assign rd     = instr[RD_HI:RD_LO];
  assign shamt  = instr[SHAMT_HI:SHAMT_LO];
  assign funct  = instr[FUNCT_HI:FUNCT_LO];
  assign imm16  = instr[IMM_HI:IMM_LO];

  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok && (count < CNT_W'(FETCH_DEPTH))) begin
          state_next = S_REQ;
          load_addr  = 1'b1;
        end
      end
      S_REQ: begin
        if (flush)         state_next = imem_gnt ? S_DRAIN : S_IDLE;
        else if (imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_next = imem_rvalid ? S_IDLE : S_DRAIN;
        end else if (imem_rvalid) begin
          // Chain straight into the next request when the pushed word still leaves room.
          if (start_ok && (count_next < CNT_W'(FETCH_DEPTH))) begin
            state_next = S_REQ;
            load_addr  = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MasterReset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load_addr) addr_q <= PC;
      if (flush)
        fault_q <= 1'b0;
      else if ((state == S_IDLE) && fetch_en && !pc_aligned)
        fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        MasterReset;
  logic [31:0] PC;
  logic        fetch_en, flush;
  logic        pc_advance, imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr, instr_pc;
  logic        instr_err, instr_valid, instr_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        misaligned_fault;

  instr_fetch dut (
    .CLK(CLK), .MasterReset(MasterReset), .PC(PC), .fetch_en(fetch_en), .flush(flush),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr(instr), .instr_pc(instr_pc), .instr_err(instr_err), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .misaligned_fault(misaligned_fault)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    logic        e;
  } ent_t;

  // Transaction-level reference: pending request, outstanding response, buffer queue, fault.
  ent_t        mq[$];
  bit          m_req, m_out, m_disc, m_fault, m_known;
  logic [31:0] m_addr, m_oaddr;
  bit          exp_adv, last_adv;

  // Memory and PC-stage stimulus state.
  bit          mem_pend;
  int          mem_dly;
  logic [31:0] mem_data;
  logic        mem_err;
  logic [31:0] pc_r;
  int          adv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered in the low phase with inputs applied; compares, advances the model, returns at next negedge.
  task automatic cycle();
    bit   e_valid, pop, idle, rsp, good, base;
    int   cur;
    ent_t e;
    #1;
    e_valid  = (mq.size() != 0);
    exp_adv  = m_req && imem_gnt && !flush && !MasterReset;
    last_adv = pc_advance;
    if (m_known) begin
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_addr);
      chk("pc_advance", pc_advance, exp_adv);
      chk("instr_valid", instr_valid, e_valid);
      chk("misaligned_fault", misaligned_fault, m_fault);
      if (e_valid) begin
        e = mq[0];
        chk("instr", instr, e.w);
        chk("instr_pc", instr_pc, e.a);
        chk("instr_err", instr_err, e.e);
        chk("opcode", opcode, e.w >> 26);
        chk("rs", rs, (e.w >> 21) & 32'h1f);
        chk("rt", rt, (e.w >> 16) & 32'h1f);
        chk("rd", rd, (e.w >> 11) & 32'h1f);
        chk("shamt", shamt, (e.w >> 6) & 32'h1f);
        chk("funct", funct, e.w & 32'h3f);
        chk("imm16", imm16, e.w & 32'hffff);
      end
    end
    pop = e_valid && instr_ready;
    if (MasterReset) begin
      mq.delete();
      m_req = 0; m_out = 0; m_disc = 0; m_fault = 0; m_addr = '0; m_oaddr = '0;
      m_known = 1;
    end else begin
      idle = !m_req && !m_out;
      rsp  = m_out && imem_rvalid;
      good = rsp && !m_disc && !flush;
      base = fetch_en && !flush && (PC[1:0] == 2'b00) && !m_fault;
      cur  = mq.size();
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (good) begin
          e.w = imem_rdata; e.a = m_oaddr; e.e = imem_err;
          mq.push_back(e);
        end
      end
      if (m_req) begin
        if (imem_gnt) begin
          m_req = 0; m_out = 1; m_oaddr = m_addr; m_disc = flush;
        end else if (flush) m_req = 0;
      end else if (rsp) begin
        m_out = 0; m_disc = 0;
      end else if (m_out && flush) m_disc = 1;
      if (flush) m_fault = 0;
      else if (idle && fetch_en && (PC[1:0] != 2'b00)) m_fault = 1;
      if (base && ((idle && cur < 2) || (good && mq.size() < 2))) begin
        m_req = 1; m_addr = PC;
      end
    end
    @(negedge CLK);
  endtask

  task automatic quiet();
    MasterReset = 0; fetch_en = 0; flush = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = '0; imem_err = 0; instr_ready = 0;
  endtask

  task automatic mem_pre(input int gnt_pct);
    imem_gnt    = m_req && !mem_pend && ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid = mem_pend && (mem_dly == 0);
    imem_rdata  = imem_rvalid ? mem_data : $urandom;
    imem_err    = imem_rvalid ? mem_err : 1'b0;
  endtask

  task automatic mem_post(input int max_dly);
    if (imem_rvalid) mem_pend = 0;
    else if (mem_pend) mem_dly--;
    if (imem_gnt) begin
      mem_pend = 1;
      mem_dly  = $urandom_range(0, max_dly);
      mem_data = $urandom;
      mem_err  = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic pc_post();
    logic [31:0] r;
    if (flush) begin
      r = $urandom;
      pc_r = ($urandom_range(0, 9) == 0) ? {r[31:2], 2'b10} : {r[31:2], 2'b00};
    end else if (exp_adv) pc_r = pc_r + 32'd4;
  endtask

  initial begin
    m_known = 0; m_req = 0; m_out = 0; m_disc = 0; m_fault = 0;
    m_addr = '0; m_oaddr = '0; mem_pend = 0; mem_dly = 0; mem_data = '0; mem_err = 0;
    PC = '0; pc_r = '0;
    quiet();
    MasterReset = 1;
    @(negedge CLK);
    cycle();
    cycle();
    MasterReset = 0;
    chk("reset_valid", instr_valid, 0);
    chk("reset_req", imem_req, 0);
    chk("reset_adv", pc_advance, 0);
    chk("reset_fault", misaligned_fault, 0);
    chk("reset_instr", instr, 0);
    chk("reset_instr_pc", instr_pc, 0);
    chk("reset_addr", imem_addr, 0);

    // Basic fetch with minimum latency.
    PC = 32'h0040_0000; fetch_en = 1;
    cycle();
    fetch_en = 0; imem_gnt = 1;
    cycle();
    chk("t033_adv", last_adv, 1);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h8C08_0004;
    cycle();
    quiet();
    chk("t033_valid", instr_valid, 1);
    chk("t033_pc", instr_pc, 32'h0040_0000);
    chk("t033_opcode", opcode, 32'h23);
    chk("t033_rs", rs, 0);
    chk("t033_rt", rt, 8);
    chk("t033_imm", imm16, 4);
    instr_ready = 1;
    cycle();
    quiet();
    chk("t033_popped", instr_valid, 0);

    // Decode stalled: buffer fills after two grants, then no further requests.
    pc_r = 32'h0000_1000; adv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      fetch_en = 1; PC = pc_r;
      mem_pre(100);
      cycle();
      mem_post(0);
      pc_post();
      adv_cnt += int'(last_adv);
    end
    quiet();
    chk("t034_adv_pulses", adv_cnt, 2);
    chk("t034_no_req", imem_req, 0);
    chk("t034_head_pc", instr_pc, 32'h0000_1000);
    instr_ready = 1;
    cycle();
    chk("t034_second_pc", instr_pc, 32'h0000_1004);
    chk("t034_second_valid", instr_valid, 1);
    cycle();
    quiet();
    chk("t034_empty", instr_valid, 0);

    // Flush coincident with grant: the late response is drained.
    PC = 32'h0000_2000; fetch_en = 1;
    cycle();
    fetch_en = 0; imem_gnt = 1; flush = 1;
    cycle();
    chk("t035_adv_suppressed", last_adv, 0);
    quiet();
    cycle();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    cycle();
    quiet();
    for (int i = 0; i < 3; i++) begin
      chk("t035_no_valid", instr_valid, 0);
      chk("t035_no_deadbeef", instr == 32'hDEAD_BEEF, 0);
      cycle();
    end

    // Misaligned PC.
    PC = 32'h0040_0002; fetch_en = 1;
    cycle();
    chk("t036_fault", misaligned_fault, 1);
    chk("t036_no_req", imem_req, 0);
    cycle();
    chk("t036_still_no_req", imem_req, 0);
    fetch_en = 0; flush = 1;
    cycle();
    quiet();
    chk("t036_cleared", misaligned_fault, 0);

    // Bus error tags the word; fetching continues.
    PC = 32'h0000_3000; fetch_en = 1;
    cycle();
    imem_gnt = 1;
    cycle();
    PC = 32'h0000_3004; imem_gnt = 0; imem_rvalid = 1; imem_err = 1; imem_rdata = 32'h0000_1111;
    cycle();
    fetch_en = 0; imem_rvalid = 0; imem_err = 0; imem_gnt = 1;
    chk("t037_err_tag", instr_err, 1);
    chk("t037_err_pc", instr_pc, 32'h0000_3000);
    cycle();
    chk("t037_next_adv", last_adv, 1);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_2222;
    cycle();
    quiet();
    instr_ready = 1;
    cycle();
    chk("t037_next_pc", instr_pc, 32'h0000_3004);
    chk("t037_next_err", instr_err, 0);
    cycle();
    quiet();

    // Reset while waiting for a response.
    PC = 32'h0000_4000; fetch_en = 1;
    cycle();
    fetch_en = 0; imem_gnt = 1;
    cycle();
    imem_gnt = 0; MasterReset = 1;
    cycle();
    MasterReset = 0; imem_rvalid = 1; imem_rdata = 32'h0000_5555;
    cycle();
    quiet();
    cycle();
    chk("t038_valid", instr_valid, 0);
    chk("t038_req", imem_req, 0);

    // Randomized traffic against the model.
    mem_pend = 0; pc_r = 32'h0001_0000;
    for (int n = 0; n < 3000; n++) begin
      MasterReset = ($urandom_range(0, 299) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      fetch_en    = ($urandom_range(0, 9) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      PC          = pc_r;
      mem_pre(70);
      cycle();
      mem_post(2);
      pc_post();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 CLK  in  1  sole clock; all state updates on the rising edge of CLK.
REQ-002 MasterReset  in  1  synchronous, active-high reset.
REQ-003 PC  in  32  fetch address from the program counter stage.
REQ-004 fetch_en  in  1  PC is valid and may be fetched.
REQ-005 flush  in  1  branch/jump redirect; discard everything buffered or in flight.
REQ-006 pc_advance  out  1  one-cycle pulse; fetch of the current PC was accepted and the PC stage may step.
REQ-007 imem_req / imem_addr  out  1 / 32  instruction-memory request and word address.
REQ-008 imem_gnt  in  1  memory accepted the request this cycle.
REQ-009 imem_rvalid / imem_rdata / imem_err  in  1 / 32 / 1  response valid, instruction word, bus error.
REQ-010 instr / instr_pc / instr_err  out  32 / 32 / 1  head of buffer: word, its address, error tag.
REQ-011 instr_valid out 1, instr_ready in 1  valid/ready handshake to decode.
REQ-012 opcode 6, rs 5, rt 5, rd 5, shamt 5, funct 6, imm16 16  out  combinational field split of instr.
REQ-013 misaligned_fault  out  1  sticky; PC[1:0] was nonzero when a fetch was attempted.

Function
REQ-014 FSM states IDLE, REQ, WAIT, DRAIN; at most one outstanding memory transaction.
REQ-015 Buffer: 2-entry FIFO of {instr, pc, err}; a request SHALL issue only when occupancy plus in-flight count is less than 2, so a response always has room.
REQ-016 IDLE -> REQ when fetch_en=1, flush=0, a slot is free, PC[1:0]=0, and misaligned_fault=0.
REQ-017 In REQ, imem_req=1 and imem_addr=PC latched on entry; both held stable until imem_gnt.
REQ-018 On imem_gnt in REQ: pc_advance=1 for exactly that cycle; next state is WAIT.
REQ-019 In WAIT, imem_rvalid pushes {imem_rdata, latched addr, imem_err}; next state is REQ if REQ-016 conditions hold using the post-push occupancy, else IDLE.
REQ-020 Minimum latency: gnt in the request cycle plus rvalid one cycle later gives instr_valid 2 cycles after REQ entry; back-to-back sustains 1 word per 2 cycles.
REQ-021 Pop when instr_valid and instr_ready; simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-022 instr_valid = (occupancy != 0); instr, instr_pc, and instr_err SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-023 flush: FIFO emptied next cycle (flush beats simultaneous push or pop); pc_advance suppressed in a flush cycle.
REQ-024 flush in REQ without gnt: imem_req withdrawn next cycle and next state is IDLE; flush in REQ with gnt: next state is DRAIN.
REQ-025 flush in WAIT: next state is DRAIN, or IDLE if imem_rvalid occurs in the same cycle (response discarded).
REQ-026 DRAIN: discard next imem_rvalid, then go to IDLE; no new request until then.
REQ-027 Misaligned PC with fetch_en in IDLE: set misaligned_fault, issue no request; the fault is cleared only by flush or reset.
REQ-028 imem_err SHALL NOT stop fetching; the word is tagged instr_err=1.

Reset
REQ-029 MasterReset: state IDLE; FIFO empty; instr_valid, imem_req, pc_advance, misaligned_fault all 0; instr, instr_pc, imem_addr 0.
REQ-030 Reset mid-transaction: a response arriving after reset SHALL be ignored (DRAIN is not entered; the in-flight flag is cleared).

Structure
REQ-031 Shared package: FSM state enum, FETCH_DEPTH=2, instruction field bit-position constants (opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0).
REQ-032 One sub-module, fetch_fifo (parameterised depth/width, push/pop/flush, count).

Verification
REQ-033 Reset, PC=0x00400000, fetch_en=1, gnt immediate, rvalid +1 with 0x8C080004 -> instr_valid with instr_pc=0x00400000, opcode=0x23, rs=0, rt=8, imm16=4.
REQ-034 instr_ready=0 and 3 fetch attempts -> exactly 2 pc_advance pulses, FIFO full, no imem_req; ready=1 -> words pop in order.
REQ-035 flush in the same cycle as gnt -> DRAIN; the later rvalid word 0xDEADBEEF never appears on instr.
REQ-036 PC=0x00400002 -> misaligned_fault=1, no imem_req; flush -> fault cleared.
REQ-037 imem_err=1 on a response -> instr_err=1 for that entry, and the next fetch proceeds normally.
REQ-038 MasterReset asserted in WAIT, rvalid one cycle later -> instr_valid remains 0.
